seven_seg_scan_ctrl: RTL and testbench

- Time-multiplexes one shared seven-segment decoder (4-bit hex in, active-low segments A..G out) across NUM_DIGITS common-anode digits.
- Per slot: presents one digit's nibble to the decoder input, then enables that digit's anode. A blanking interval between slots suppresses ghosting.
- Frame-synchronous shadow register keeps the display tear-free when the caller updates values mid-frame.

---
 rtl/seven_seg_scan_ctrl.sv | 167 ++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: scans NUM_DIGITS common-anode digits through one shared hex decoder.
// Each slot starts with BLANK_CYCLES of all anodes off while x settles, then lights one digit.
// A shadow register updated only at frame wrap keeps the display tear-free.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppress leading-zero digits, digit 0 excepted).
module seven_seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SLOT_CYCLES  = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [3:0]              x,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int unsigned CntW = $clog2(SLOT_CYCLES);
    localparam int unsigned IdxW = $clog2(NUM_DIGITS);

    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
    localparam logic [CntW-1:0] SlotLast  = CntW'(SLOT_CYCLES - 1);
    localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {StBlank, StOn} state_e;

    state_e                      state_q, state_d;
    logic [CntW-1:0]             slot_cnt_q, slot_cnt_d;
    logic [IdxW-1:0]             idx_q, idx_d;
    logic [3:0]                  x_q, x_d;
    logic                        frame_done_q, frame_done_d;
    logic [NUM_DIGITS-1:0][3:0]  staging_q, staging_d;
    logic [NUM_DIGITS-1:0]       staging_dp_q, staging_dp_d;
    logic [NUM_DIGITS-1:0][3:0]  shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]       shadow_dp_q, shadow_dp_d;
    logic                        pending_q, pending_d;
    logic                        slot_end;
    logic                        suppress;

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] upper_zero;

    // upper_zero[i]: shadow nibble i and every higher-index nibble are zero
    always_comb begin
        upper_zero = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            upper_zero[i] = 1'b1;
            for (int j = i; j < NUM_DIGITS; j++) begin
                if (shadow_q[j] != 4'h0) begin
                    upper_zero[i] = 1'b0;
                end
            end
        end
    end

    // A requested decimal point keeps an otherwise-suppressed digit lit
    assign suppress = (idx_q != '0) && upper_zero[idx_q] && !shadow_dp_q[idx_q];
`else
    assign suppress = 1'b0;
`endif

    // Next-state: slot timing, digit advance, frame-boundary shadow transfer, staging capture
    always_comb begin
        state_d      = state_q;
        slot_cnt_d   = slot_cnt_q;
        idx_d        = idx_q;
        x_d          = x_q;
        frame_done_d = 1'b0;
        staging_d    = staging_q;
        staging_dp_d = staging_dp_q;
        shadow_d     = shadow_q;
        shadow_dp_d  = shadow_dp_q;
        pending_d    = pending_q;
        slot_end     = 1'b0;

        if (!enable) begin
            // Park in a fresh blank slot so re-enable starts from slot_cnt = 0
            state_d    = StBlank;
            slot_cnt_d = '0;
        end else begin
            slot_cnt_d = (slot_cnt_q == SlotLast) ? '0 : slot_cnt_q + 1'b1;
            case (state_q)
                StBlank: begin
                    if (slot_cnt_q == BlankLast) begin
                        state_d = StOn;
                    end
                end
                StOn: begin
                    if (slot_cnt_q == SlotLast) begin
                        state_d  = StBlank;
                        slot_end = 1'b1;
                        idx_d    = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
                    end
                end
                default: state_d = StBlank;
            endcase
        end

        if (slot_end && (idx_q == IdxLast)) begin
            frame_done_d = 1'b1;
            if (pending_q) begin
                shadow_d    = staging_q;
                shadow_dp_d = staging_dp_q;
                pending_d   = 1'b0;
            end
        end

        // A load on the wrap edge lands in staging after the old staging moved to shadow
        if (load) begin
            staging_d    = digits_in;
            staging_dp_d = dp_in;
            pending_d    = 1'b1;
        end

        // Present the next digit's nibble during its blanking interval
        if (slot_end) begin
            x_d = shadow_d[idx_d];
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StBlank;
            slot_cnt_q   <= '0;
            idx_q        <= '0;
            x_q          <= 4'h0;
            frame_done_q <= 1'b0;
            staging_q    <= '0;
            staging_dp_q <= '0;
            shadow_q     <= '0;
            shadow_dp_q  <= '0;
            pending_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_cnt_q   <= slot_cnt_d;
            idx_q        <= idx_d;
            x_q          <= x_d;
            frame_done_q <= frame_done_d;
            staging_q    <= staging_d;
            staging_dp_q <= staging_dp_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            pending_q    <= pending_d;
        end
    end

    // Anode/dp drive: at most one anode low, all off while blanking or disabled
    always_comb begin
        an = '1;
        dp = 1'b1;
        if (enable && (state_q == StOn)) begin
            if (!suppress) begin
                an[idx_q] = 1'b0;
            end
            dp = ~shadow_dp_q[idx_q];
        end
    end

    assign x          = x_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: directed bench for seven_seg_scan_ctrl (4 digits, 8-cycle slots, 2 blank).
// Expected digit slots are queued when stimulus is driven and popped as the DUT lights each digit.
`timescale 1ns/1ps
module tb_seven_seg_scan_ctrl;

    localparam int unsigned N     = 4;
    localparam int unsigned SLOT  = 8;
    localparam int unsigned BLANK = 2;
    localparam int unsigned TMO   = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  x;
    logic [3:0]  an;
    logic        dp;
    logic        frame_done;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] x;
        logic       dp;
    } exp_t;

    exp_t sb[$];

    seven_seg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .SLOT_CYCLES  (SLOT),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .x          (x),
        .an         (an),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Never more than one anode low
    always @(negedge clk) begin
        tests++;
        assert ($countones(~an) <= 1) else begin
            fails++;
            $error("FAIL an_onehot: observed an=%b, required at most one bit low", an);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_tmo(input string tag, input int unsigned n);
        tests++;
        assert (n < TMO) else begin
            fails++;
            $error("FAIL %s: observed wait of %0d cycles, expected fewer than %0d", tag, n, TMO);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] a, input logic [3:0] xv, input logic d);
        exp_t e;
        e.an = a;
        e.x  = xv;
        e.dp = d;
        return e;
    endfunction

    task automatic wait_fd(input string tag);
        int unsigned n = 0;
        while (frame_done !== 1'b1 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        chk_tmo(tag, n);
    endtask

    task automatic wait_an(input string tag, input logic [3:0] target);
        int unsigned n = 0;
        while (an !== target && n < TMO) begin
            @(negedge clk);
            n++;
        end
        chk_tmo(tag, n);
    endtask

    // Pop one expected slot per lit digit; check digit, nibble, dp, on-time and gap
    task automatic check_slots(input int unsigned count, input bit chk_blank);
        exp_t        e;
        int unsigned n;
        for (int k = 0; k < int'(count); k++) begin
            e = sb.pop_front();
            if (k == 0) begin
                n = 0;
                while (an !== 4'hF && n < TMO) begin
                    @(negedge clk);
                    n++;
                end
                chk_tmo($sformatf("slot%0d_sync", k), n);
            end
            n = 0;
            while (an === 4'hF && n < TMO) begin
                @(negedge clk);
                n++;
            end
            chk_tmo($sformatf("slot%0d_lit", k), n);
            if (k != 0 && chk_blank) chk($sformatf("slot%0d_blank_len", k), 32'(n), 32'(BLANK));
            chk($sformatf("slot%0d_an", k), 32'(an), 32'(e.an));
            chk($sformatf("slot%0d_x", k), 32'(x), 32'(e.x));
            chk($sformatf("slot%0d_dp", k), 32'(dp), 32'(e.dp));
            n = 0;
            while (an === e.an && n < TMO) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("slot%0d_on_len", k), 32'(n), 32'(SLOT - BLANK));
        end
    endtask

    initial begin
        int unsigned n;

        // Reset / idle
        reset = 1'b1; enable = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_x", 32'(x), 32'h0);
        chk("rst_fd", 32'(frame_done), 32'h0);
        reset = 1'b0;
        n = 0;
        while (an === 4'hF && n < TMO) begin
            n++;
            @(negedge clk);
        end
        chk("rst_blank_len", 32'(n), 32'(BLANK));
        chk("rst_first_an", 32'(an), 32'hE);

        // Scan order after one frame boundary
        digits_in = 16'h1A3F; dp_in = 4'b0100; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_fd("scan_fd");
        chk("scan_fd_x", 32'(x), 32'hF);
        sb.push_back(mk(4'b1110, 4'hF, 1'b1));
        sb.push_back(mk(4'b1101, 4'h3, 1'b1));
        sb.push_back(mk(4'b1011, 4'hA, 1'b0));
        sb.push_back(mk(4'b0111, 4'h1, 1'b1));
        check_slots(4, 1'b1);

        // frame_done width and period
        wait_fd("per_fd");
        @(negedge clk);
        chk("fd_width", 32'(frame_done), 32'h0);
        n = 1;
        while (frame_done !== 1'b1 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        chk("fd_period", 32'(n), 32'(SLOT * N));

        // Tear-free update: two loads mid-frame, last one wins at next frame
        wait_an("tear_sync", 4'b1101);
        digits_in = 16'h1234; dp_in = 4'b0000; load = 1'b1;
        @(negedge clk);
        digits_in = 16'h5678;
        @(negedge clk);
        load = 1'b0;
        sb.push_back(mk(4'b1011, 4'hA, 1'b0));
        sb.push_back(mk(4'b0111, 4'h1, 1'b1));
        sb.push_back(mk(4'b1110, 4'h8, 1'b1));
        sb.push_back(mk(4'b1101, 4'h7, 1'b1));
        sb.push_back(mk(4'b1011, 4'h6, 1'b1));
        sb.push_back(mk(4'b0111, 4'h5, 1'b1));
        check_slots(6, 1'b1);

        // Enable freeze during digit 2
        wait_an("frz_sync", 4'b1011);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("frz%0d_an", i), 32'(an), 32'hF);
            chk($sformatf("frz%0d_x", i), 32'(x), 32'h6);
        end
        enable = 1'b1;
        n = 0;
        while (an === 4'hF && n < TMO) begin
            n++;
            @(negedge clk);
        end
        chk("frz_resume_blank", 32'(n), 32'(BLANK));
        chk("frz_resume_an", 32'(an), 32'hB);
        chk("frz_resume_x", 32'(x), 32'h6);
        chk("frz_resume_dp", 32'(dp), 32'h1);

        // Reset mid-slot with a load pending
        wait_an("rst2_sync", 4'b1101);
        digits_in = 16'h9ABC; dp_in = 4'b1111; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("rst2_pre_an", 32'(an), 32'hD);
        reset = 1'b1;
        @(negedge clk);
        chk("rst2_an", 32'(an), 32'hF);
        chk("rst2_x", 32'(x), 32'h0);
        chk("rst2_dp", 32'(dp), 32'h1);
        chk("rst2_fd", 32'(frame_done), 32'h0);
        reset = 1'b0;
        for (int f = 0; f < 2; f++) begin
            sb.push_back(mk(4'b1110, 4'h0, 1'b1));
            sb.push_back(mk(4'b1101, 4'h0, 1'b1));
            sb.push_back(mk(4'b1011, 4'h0, 1'b1));
            sb.push_back(mk(4'b0111, 4'h0, 1'b1));
        end
        check_slots(8, 1'b1);

        // Leading zeros: suppressed with the feature, shown without it
        digits_in = 16'h0070; dp_in = 4'b0000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_fd("lz_fd0");
        sb.push_back(mk(4'b1110, 4'h0, 1'b1));
        sb.push_back(mk(4'b1101, 4'h7, 1'b1));
`ifdef LEADING_ZERO_BLANK_EN
        check_slots(2, 1'b0);
`else
        sb.push_back(mk(4'b1011, 4'h0, 1'b1));
        sb.push_back(mk(4'b0111, 4'h0, 1'b1));
        check_slots(4, 1'b1);
`endif
        dp_in = 4'b1000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_fd("lz_fd1");
        sb.push_back(mk(4'b1110, 4'h0, 1'b1));
        sb.push_back(mk(4'b1101, 4'h7, 1'b1));
`ifdef LEADING_ZERO_BLANK_EN
        sb.push_back(mk(4'b0111, 4'h0, 1'b0));
        check_slots(3, 1'b0);
`else
        sb.push_back(mk(4'b1011, 4'h0, 1'b1));
        sb.push_back(mk(4'b0111, 4'h0, 1'b0));
        check_slots(4, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
